// File: rtl/spatial_mult_pkg.sv
// Shared sizing helpers for the spatial multiplier B-operand path.
// The B input mux and the operand packer derive their widths from the same
// functions here, so the packed word always matches the mux width.
package spatial_mult_pkg;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of lowest-precision beats that make up one top-level operand.
  function automatic int beats_of(input int precision, input int l_precision);
    return precision / l_precision;
  endfunction

  // Packed word width seen by the B input mux.
  function automatic int data_width_of(input int precision, input int l_precision);
    return (precision / l_precision) * precision;
  endfunction

  // Width needed to hold a beat count of 0..BEATS.
  function automatic int cnt_width_of(input int precision, input int l_precision);
    return clog2((precision / l_precision) + 1);
  endfunction

endpackage

// File: rtl/operand_b_packer_if.sv
// Bundles the beat stream (s_*) and the packed word stream (m_*) of the
// B-operand packer.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// Once valid is raised the producer holds it and its payload until the
// transfer; ready may be raised or dropped freely and never waits on valid.
interface operand_b_packer_if #(
  parameter int PRECISION  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 3
);
  logic                  s_valid;
  logic                  s_ready;
  logic [PRECISION-1:0]  s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CNT_W-1:0]      m_count;
  logic                  m_last;

  // Upstream beat source and downstream word consumer.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count, m_last
  );

  // The packer itself.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count, m_last
  );
endinterface

// File: rtl/sm_fifo2.sv
// Generic 2-entry FIFO with registered outputs. The head always lives in
// mem0 so out_data is a flop output; in_ready depends only on occupancy.
module sm_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   occ;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and storage update; a pop shifts mem1 forward and clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) mem0 <= in_data;
          else             mem1 <= in_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          mem1 <= '0;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Only reachable at occupancy 1: the head leaves, the new word replaces it.
          mem0 <= in_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/operand_b_packer.sv
// Packs PRECISION-bit B-operand beats into DATA_WIDTH words for the spatial
// multiplier's B input mux. Beat k of a word lands at bits k*PRECISION; a word
// closes after BEATS beats or early on s_last, with unused beats left zero.
// Closed words wait in a 2-entry queue; while it is full no beats are taken,
// so a partially filled word simply holds.
module operand_b_packer
  import spatial_mult_pkg::*;
#(
  parameter int PRECISION   = 8,
  parameter int L_PRECISION = 2,
  parameter int DATA_WIDTH  = data_width_of(PRECISION, L_PRECISION)
) (
  input  logic               clk,
  input  logic               resetn,
  operand_b_packer_if.slave  bus,
  output logic [0:0]         fill_state
);
  localparam int BEATS   = beats_of(PRECISION, L_PRECISION);
  localparam int CNT_W   = cnt_width_of(PRECISION, L_PRECISION);
  localparam int ENTRY_W = DATA_WIDTH + CNT_W + 1;

  localparam logic [0:0] EMPTY   = 1'b0;
  localparam logic [0:0] FILLING = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] fill;
  logic [DATA_WIDTH-1:0] word;
  logic [0:0]            state;
  logic                  fifo_in_ready;
  logic                  accept;
  logic                  close;
  logic [ENTRY_W-1:0]    entry;
  logic [ENTRY_W-1:0]    head;

  assign accept      = bus.s_valid && fifo_in_ready;
  assign close       = accept && (bus.s_last || (cnt == LAST_IDX));
  assign bus.s_ready = fifo_in_ready;
  assign fill_state  = state;

  // Current fill with the incoming beat merged into its slot.
  always_comb begin
    word = fill;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt == CNT_W'(k)) word[k*PRECISION +: PRECISION] = bus.s_data;
    end
  end

  assign entry = {word, cnt + CNT_W'(1), bus.s_last};

  // Beat counter, fill register and EMPTY/FILLING state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      fill  <= '0;
      state <= EMPTY;
    end else if (close) begin
      cnt   <= '0;
      fill  <= '0;
      state <= EMPTY;
    end else if (accept) begin
      cnt   <= cnt + CNT_W'(1);
      fill  <= word;
      state <= FILLING;
    end
  end

  sm_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (close),
    .in_ready  (fifo_in_ready),
    .in_data   (entry),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (head)
  );

  assign {bus.m_data, bus.m_count, bus.m_last} = head;
endmodule

// File: tb/tb_operand_b_packer.sv
// Bench for operand_b_packer: an 8-bit/4-beat instance (A) and a degenerate
// 2-bit/1-beat instance (B), sharing clock and reset.
module tb_operand_b_packer;
  logic clk = 1'b0;
  logic resetn;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  operand_b_packer_if #(.PRECISION(8), .DATA_WIDTH(32), .CNT_W(3)) bus_a ();
  operand_b_packer_if #(.PRECISION(2), .DATA_WIDTH(2),  .CNT_W(1)) bus_b ();
  logic [0:0] state_a;
  logic [0:0] state_b;

  operand_b_packer #(.PRECISION(8), .L_PRECISION(2), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a), .fill_state(state_a)
  );
  operand_b_packer #(.PRECISION(2), .L_PRECISION(2), .DATA_WIDTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b), .fill_state(state_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (instance A) ----------------
  // Entries are {data[31:0], count[2:0], last}.
  logic [35:0] exp_q[$];
  logic [7:0]  cur_beats[$];

  function automatic logic [35:0] pack_word(input logic last);
    logic [31:0] data;
    data = 32'h0;
    for (int i = 0; i < cur_beats.size(); i++) data = data | (32'(cur_beats[i]) << (8 * i));
    return {data, 3'(cur_beats.size()), last};
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      cur_beats.delete();
    end else begin
      check("s_ready_vs_model", 64'(bus_a.s_ready), 64'(exp_q.size() != 2));
      check("m_valid_vs_model", 64'(bus_a.m_valid), 64'(exp_q.size() != 0));
      if (bus_a.m_valid && exp_q.size() != 0)
        check("head_word", 64'({bus_a.m_data, bus_a.m_count, bus_a.m_last}), 64'(exp_q[0]));
      if (bus_a.m_valid && bus_a.m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus_a.s_valid && bus_a.s_ready) begin
        cur_beats.push_back(bus_a.s_data);
        if (bus_a.s_last || cur_beats.size() == 4) begin
          exp_q.push_back(pack_word(bus_a.s_last));
          cur_beats.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the edge that took the beat.
  task automatic beat_a(input logic [7:0] d, input logic l);
    bit acc;
    int budget;
    acc = 0;
    budget = 50;
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = d;
    bus_a.s_last  = l;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = bus_a.s_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    bus_a.s_valid = 1'b0;
    bus_a.s_last  = 1'b0;
    if (!acc) check("beat_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] beats;
    logic        last;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_last;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int n, input logic [31:0] b, input logic l,
                              input logic [31:0] ed, input logic [2:0] ec, input logic el);
    vec_t v;
    v.n = n; v.beats = b; v.last = l; v.exp_data = ed; v.exp_count = ec; v.exp_last = el;
    return v;
  endfunction

  // Watchdog: a hung handshake still ends with a report.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int got;
    int budget;
    int accepted;
    int cyc;
    bit sacc;
    bit pop;
    logic [31:0] want[3];
    logic [31:0] held;

    vecs[0] = mk(4, 32'h44332211, 1'b0, 32'h44332211, 3'd4, 1'b0);
    vecs[1] = mk(2, 32'hDEADBBAA, 1'b1, 32'h0000BBAA, 3'd2, 1'b1);
    vecs[2] = mk(4, 32'h00FF00FF, 1'b1, 32'h00FF00FF, 3'd4, 1'b1);
    vecs[3] = mk(1, 32'hCAFE005A, 1'b1, 32'h0000005A, 3'd1, 1'b1);
    vecs[4] = mk(3, 32'h99030201, 1'b1, 32'h00030201, 3'd3, 1'b1);
    vecs[5] = mk(4, 32'hA5C3E10F, 1'b0, 32'hA5C3E10F, 3'd4, 1'b0);
    want[0] = 32'h04030201;
    want[1] = 32'h08070605;
    want[2] = 32'h0C0B0A09;

    resetn = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.s_last = 1'b0; bus_a.m_ready = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.s_last = 1'b0; bus_b.m_ready = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);

    // Reset state
    check("rst_s_ready", 64'(bus_a.s_ready), 64'(1));
    check("rst_m_valid", 64'(bus_a.m_valid), 64'(0));
    check("rst_m_data",  64'(bus_a.m_data),  64'(0));
    check("rst_m_count", 64'(bus_a.m_count), 64'(0));
    check("rst_m_last",  64'(bus_a.m_last),  64'(0));
    check("rst_state",   64'(state_a),       64'(0));
    check("rst_b_valid", 64'(bus_b.m_valid), 64'(0));

    // Table-driven words, m_ready held high; output checked one cycle after close
    bus_a.m_ready = 1'b1;
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++)
        beat_a(vecs[v].beats[8*i +: 8], vecs[v].last && (i == vecs[v].n - 1));
      check("vec_m_valid", 64'(bus_a.m_valid), 64'(1));
      check("vec_m_data",  64'(bus_a.m_data),  64'(vecs[v].exp_data));
      check("vec_m_count", 64'(bus_a.m_count), 64'(vecs[v].exp_count));
      check("vec_m_last",  64'(bus_a.m_last),  64'(vecs[v].exp_last));
    end

    // Idle cycles mid-word keep the partial fill
    beat_a(8'h12, 1'b0);
    check("filling_state", 64'(state_a), 64'(1));
    idle(3);
    check("filling_held", 64'(state_a), 64'(1));
    beat_a(8'h34, 1'b0);
    beat_a(8'h56, 1'b0);
    beat_a(8'h78, 1'b0);
    check("bubble_word", 64'(bus_a.m_data), 64'(32'h78563412));
    check("empty_state", 64'(state_a), 64'(0));
    idle(3);

    // Backpressure: 12 beats offered with m_ready low, only 8 fit
    bus_a.m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus_a.s_valid = 1'b1;
      bus_a.s_data  = 8'(idx + 1);
      @(negedge clk);
      sacc = bus_a.s_ready;
      @(posedge clk);
      #1;
      if (sacc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(8));
    check("bp_s_ready",  64'(bus_a.s_ready), 64'(0));
    check("bp_m_data",   64'(bus_a.m_data),  64'(32'h04030201));
    check("bp_m_count",  64'(bus_a.m_count), 64'(4));
    held = bus_a.m_data;
    idle(3);
    check("bp_stable", 64'(bus_a.m_data), 64'(held));
    bus_a.m_ready = 1'b1;
    got = 0;
    budget = 40;
    while ((got < 3 || idx < 12) && budget > 0) begin
      if (idx < 12) begin
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = 8'(idx + 1);
      end else begin
        bus_a.s_valid = 1'b0;
      end
      @(negedge clk);
      pop  = bus_a.m_valid && bus_a.m_ready;
      sacc = bus_a.s_valid && bus_a.s_ready;
      if (pop && got < 3) begin
        check("bp_order", 64'(bus_a.m_data), 64'(want[got]));
        got++;
      end
      @(posedge clk);
      #1;
      if (sacc) idx++;
      budget--;
    end
    bus_a.s_valid = 1'b0;
    check("bp_words_out", 64'(got), 64'(3));
    idle(2);

    // Asynchronous reset with one queued word and a half-built word
    bus_a.m_ready = 1'b0;
    beat_a(8'hA1, 1'b0); beat_a(8'hA2, 1'b0); beat_a(8'hA3, 1'b0); beat_a(8'hA4, 1'b0);
    beat_a(8'hB1, 1'b0); beat_a(8'hB2, 1'b0);
    check("pre_rst_state", 64'(state_a), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("arst_m_valid", 64'(bus_a.m_valid), 64'(0));
    check("arst_m_data",  64'(bus_a.m_data),  64'(0));
    check("arst_m_count", 64'(bus_a.m_count), 64'(0));
    check("arst_m_last",  64'(bus_a.m_last),  64'(0));
    check("arst_state",   64'(state_a),       64'(0));
    #3;
    resetn = 1'b1;
    idle(1);
    check("post_rst_s_ready", 64'(bus_a.s_ready), 64'(1));
    bus_a.m_ready = 1'b1;
    beat_a(8'h55, 1'b0); beat_a(8'h66, 1'b0); beat_a(8'h77, 1'b0); beat_a(8'h88, 1'b0);
    check("post_rst_data",  64'(bus_a.m_data),  64'(32'h88776655));
    check("post_rst_count", 64'(bus_a.m_count), 64'(4));
    check("post_rst_last",  64'(bus_a.m_last),  64'(0));
    idle(2);

    // Degenerate one-beat words: one word per cycle
    bus_b.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b_s_ready", 64'(bus_b.s_ready), 64'(1));
      bus_b.s_valid = 1'b1;
      bus_b.s_data  = 2'(i);
      idle(1);
      check("b_m_valid", 64'(bus_b.m_valid), 64'(1));
      check("b_m_data",  64'(bus_b.m_data),  64'(i));
      check("b_m_count", 64'(bus_b.m_count), 64'(1));
      check("b_m_last",  64'(bus_b.m_last),  64'(0));
    end
    bus_b.s_valid = 1'b0;
    idle(2);

    // Random bubbles on both sides against the scoreboard
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      if (!bus_a.s_valid && $urandom_range(0, 3) != 0) begin
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = 8'($urandom_range(0, 255));
        bus_a.s_last  = ($urandom_range(0, 4) == 0);
      end
      bus_a.m_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      sacc = bus_a.s_valid && bus_a.s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (sacc) begin
        accepted++;
        bus_a.s_valid = 1'b0;
        bus_a.s_last  = 1'b0;
      end
    end
    check("rand_beats", 64'(accepted), 64'(10000));
    bus_a.m_ready = 1'b1;
    beat_a(8'h5E, 1'b1);
    idle(4);
    check("drain_model_empty", 64'(exp_q.size()), 64'(0));
    check("drain_m_valid", 64'(bus_a.m_valid), 64'(0));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_b_packer.md
Name: operand_b_packer

Overview:
- Upstream stage of the spatial multiplier's B-operand input mux.
- Accepts B data one PRECISION-bit beat per cycle over a valid/ready stream and packs beats into one DATA_WIDTH word.
- Buffers completed words in a 2-entry output queue and presents them to the B input mux over valid/ready.
- Supports early word termination with zero padding for ragged tile edges.

Parameters:
- PRECISION, 8: precision at the top multiplier level; width of one input beat.
- L_PRECISION, 2: lowest supported precision.
- DATA_WIDTH, (PRECISION/L_PRECISION)*PRECISION: packed output word width; must match the B input mux width.
- BEATS, PRECISION/L_PRECISION: beats per full word (derived; not to be overridden).
- CNT_W, clog2(BEATS+1): width of the beat-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  PRECISION  input beat.
- s_last  in  1  final beat of the current word; qualified by s_valid.
- m_valid  out  1  packed word available.
- m_ready  in  1  consumer (B input mux path) accepts the word.
- m_data  out  DATA_WIDTH  packed word.
- m_count  out  CNT_W  number of real beats in m_data (1..BEATS).
- m_last  out  1  word was closed early by s_last.

Behaviour:
- Packing: the k-th accepted beat of a word lands at m_data[k*PRECISION +: PRECISION]. Beat 0 occupies the LSBs. Unfilled beats are zero.
- Fill state:
  - beat counter cnt, 0..BEATS-1, plus a fill register.
  - FSM states: EMPTY (cnt==0) and FILLING (cnt>0).
  - An accepted beat with cnt==BEATS-1, or with s_last=1, closes the word.
  - Closing pushes {fill with this beat, count=cnt+1, last=s_last} into the queue in the same cycle.
  - On close, cnt returns to 0 and the fill register clears to 0.
  - Any other accepted beat increments cnt.
- s_last on the BEATS-1 beat: word is full, m_count=BEATS, m_last=1.
- Queue: 2 entries, FIFO order.
  - m_valid = (occupancy != 0).
  - m_data, m_count and m_last come from the head entry; they are registered outputs with no combinational path from s_*.
- s_ready = (occupancy != 2).
  - s_ready depends only on registered state; no combinational path from m_ready.
  - While the queue is full, no beats are accepted, even mid-word; the partial word is held intact.
- Simultaneous push and pop: allowed at occupancy 1 (stays 1) and at occupancy 2 (pop only, since s_ready=0).
- Latency: word-closing beat accepted at cycle t gives m_valid=1 at t+1.
- Throughput: sustains 1 beat/cycle with m_ready=1, including BEATS==1.
- Output stability: m_data/m_count/m_last stay stable while m_valid && !m_ready.
- Reset (asynchronous, any time, including mid-word or with the queue full):
  - cnt=0, fill=0, occupancy=0, partial word discarded.
  - Outputs: s_ready=1 (after reset deasserts), m_valid=0, m_data=0, m_count=0, m_last=0.
- Idle cycles: s_valid low mid-word leaves cnt and fill unchanged; there is no timeout.

Decomposition:
- Shared package/header spatial_mult_pkg: clog2 function, BEATS and CNT_W derivation, DATA_WIDTH formula. The input mux and this block use the same formula.
- One sub-module: sm_fifo2, a generic 2-entry registered FIFO with width parameter, valid/ready on both sides, async active-low reset. The packer instantiates it with width DATA_WIDTH+CNT_W+1.

Test Plan:
- PRECISION=8, m_ready=1: beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> one cycle after the 4th beat, m_data=0x44332211, m_count=4, m_last=0.
- Early close: beats 0xAA, then 0xBB with s_last=1 -> m_data=0x0000BBAA, m_count=2, m_last=1. Next word starts at beat 0 with a zeroed fill.
- Backpressure: m_ready=0, stream 12 beats (0x01..0x0C) back to back -> 8 beats accepted, s_ready low the cycle after the 8th acceptance. m_data holds 0x04030201 stable. Raise m_ready -> 0x04030201, 0x08070605, 0x0C0B0A09 in order, no loss or duplication.
- Reset mid-operation: 2 beats into a word plus 1 queued word, pulse resetn low asynchronously between edges -> m_valid=0 and outputs 0 immediately. After release, beats 0x55,0x66,0x77,0x88 give 0x88776655 with no residue.
- Random bubbles on s_valid and m_ready (10k beats, random s_last) -> scoreboard matches packed words, counts and last flags exactly. Assertion: no accepted beat while occupancy==2.
- Degenerate PRECISION=L_PRECISION=2 (BEATS=1): continuous beats 0,1,2,3 with m_ready=1 -> one word per cycle, m_count=1, full throughput.
